// File: rtl/column_rasterizer.sv
// Expands one column descriptor from the DDA-out FIFO into SCREEN_HEIGHT frame-buffer writes,
// ceiling then wall then floor, walking the address down the column by SCREEN_WIDTH per row.
module column_rasterizer #(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240,
    parameter int unsigned ADDR_WIDTH    = 17,
    parameter logic [15:0] CEIL_COLOR    = 16'h2104,
    parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  logic                  dda_fifo_tvalid_in,
    input  logic [37:0]           dda_fifo_tdata_in,
    input  logic                  dda_fifo_tlast_in,
    output logic                  transformer_tready_out,
    input  logic                  ray_ready_in,
    output logic                  ray_valid_out,
    output logic [ADDR_WIDTH-1:0] ray_address_out,
    output logic [15:0]           ray_pixel_out,
    output logic                  ray_last_pixel_out,
    output logic                  err_out
);

    localparam int unsigned YW = $clog2(SCREEN_HEIGHT);
    localparam int unsigned WW = YW + 1;

    typedef enum logic [0:0] {StIdle, StDraw} state_e;

    state_e state_q, state_d;

    logic [8:0]            hcount;
    logic [7:0]            line_height;
    logic                  wall_type;
    logic [3:0]            map_data;
    logic                  accept, in_range, beat_done, last_row;
    logic [WW-1:0]         start_calc, end_calc;
    logic [15:0]           wall_calc;
    logic [4:0]            r5, b5;
    logic [5:0]            g6;

    logic                  armed_q;
    logic                  err_q;
    logic                  last_q;
    logic [YW-1:0]         y_q;
    logic [WW-1:0]         draw_start_q, draw_end_q;
    logic [15:0]           wall_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign hcount      = dda_fifo_tdata_in[37:29];
    assign line_height = dda_fifo_tdata_in[28:21];
    assign wall_type   = dda_fifo_tdata_in[20];
    assign map_data    = dda_fifo_tdata_in[19:16];

    // armed_q keeps tready low while reset is asserted and for the first cycle after release
    assign transformer_tready_out = (state_q == StIdle) && armed_q;
    assign accept    = dda_fifo_tvalid_in && transformer_tready_out;
    assign in_range  = 32'(hcount) < SCREEN_WIDTH;
    assign beat_done = (state_q == StDraw) && ray_ready_in;
    assign last_row  = y_q == YW'(SCREEN_HEIGHT - 1);

    always_comb begin
        start_calc = '0;
        end_calc   = WW'(SCREEN_HEIGHT - 1);
        if (32'(line_height) < SCREEN_HEIGHT) begin
            start_calc = WW'((SCREEN_HEIGHT - 32'(line_height)) >> 1);
            end_calc   = WW'(((SCREEN_HEIGHT - 32'(line_height)) >> 1) + 32'(line_height) - 1);
        end
    end

    always_comb begin
        r5 = map_data[0] ? 5'd31 : 5'd8;
        g6 = map_data[1] ? 6'd63 : 6'd16;
        b5 = map_data[2] ? 5'd31 : 5'd8;
        if (wall_type) begin
            r5 = r5 >> 1;
            g6 = g6 >> 1;
            b5 = b5 >> 1;
        end
        wall_calc = (map_data == 4'd0) ? 16'hF81F : {r5, g6, b5};
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && in_range) state_d = StDraw;
            StDraw: if (beat_done && last_row) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            armed_q      <= 1'b0;
            err_q        <= 1'b0;
            last_q       <= 1'b0;
            y_q          <= '0;
            draw_start_q <= '0;
            draw_end_q   <= '0;
            wall_q       <= '0;
            addr_q       <= '0;
        end else begin
            armed_q <= 1'b1;
            if (accept && !in_range) begin
                err_q <= 1'b1;
            end
            if (accept && in_range) begin
                last_q       <= dda_fifo_tlast_in;
                y_q          <= '0;
                draw_start_q <= start_calc;
                draw_end_q   <= end_calc;
                wall_q       <= wall_calc;
                addr_q       <= ADDR_WIDTH'(hcount);
            end else if (beat_done) begin
                y_q    <= y_q + YW'(1);
                addr_q <= addr_q + ADDR_WIDTH'(SCREEN_WIDTH);
            end
        end
    end

    always_comb begin
        ray_valid_out      = state_q == StDraw;
        ray_address_out    = addr_q;
        ray_last_pixel_out = ray_valid_out && last_q && last_row;
        ray_pixel_out      = 16'h0000;
        if (ray_valid_out) begin
            if ({1'b0, y_q} < draw_start_q) begin
                ray_pixel_out = CEIL_COLOR;
            end else if ({1'b0, y_q} > draw_end_q) begin
                ray_pixel_out = FLOOR_COLOR;
            end else begin
                ray_pixel_out = wall_q;
            end
        end
    end

    assign err_out = err_q;

endmodule

// File: tb/tb_column_rasterizer.sv
// Directed bench for column_rasterizer: table of column descriptors with hand-computed draw
// windows and wall colours, plus reset, stall, out-of-range and mid-column reset sequences.
module tb_column_rasterizer;

    localparam int SW = 320;
    localparam int SH = 240;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid;
    logic [37:0] tdata;
    logic        tlast;
    logic        tready;
    logic        ray_ready;
    logic        valid;
    logic [16:0] addr;
    logic [15:0] pixel;
    logic        last;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    column_rasterizer dut (
        .pixel_clk_in           (clk),
        .rst_in                 (rst_n),
        .dda_fifo_tvalid_in     (tvalid),
        .dda_fifo_tdata_in      (tdata),
        .dda_fifo_tlast_in      (tlast),
        .transformer_tready_out (tready),
        .ray_ready_in           (ray_ready),
        .ray_valid_out          (valid),
        .ray_address_out        (addr),
        .ray_pixel_out          (pixel),
        .ray_last_pixel_out     (last),
        .err_out                (err)
    );

    typedef struct {
        logic [8:0]  hcount;
        logic [7:0]  lh;
        logic        wt;
        logic [3:0]  md;
        logic        tl;
        bit          stall;
        int          ds;
        int          de;
        logic [15:0] wall;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_desc(input vec_t v);
        int waitc = 0;
        @(negedge clk);
        while (!tready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("tready_before_send", {31'd0, tready}, 32'd1);
        tvalid = 1'b1;
        tdata  = {v.hcount, v.lh, v.wt, v.md, 16'hBEEF};
        tlast  = v.tl;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
    endtask

    task automatic run_column(input vec_t v);
        int k = 0;
        int cyc = 0;
        int pix_bad = 0, addr_bad = 0, last_bad = 0, hold_bad = 0, gap_bad = 0, rdy_bad = 0;
        bit prev_stall = 0;
        logic [16:0] pa;
        logic [15:0] pp, ep;
        logic pl;
        send_desc(v);
        ray_ready = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (k < SH && cyc < 3000) begin
            @(negedge clk);
            if (cyc == 0) chk("first_beat_valid", {31'd0, valid}, 32'd1);
            if (tready) rdy_bad++;
            if (!valid) begin
                gap_bad++;
            end else begin
                ep = (k < v.ds) ? 16'h2104 : (k > v.de) ? 16'h4208 : v.wall;
                if (pixel !== ep) pix_bad++;
                if (int'(addr) != int'(v.hcount) + k * SW) addr_bad++;
                if (last !== (v.tl && k == SH - 1)) last_bad++;
                if (prev_stall && (addr !== pa || pixel !== pp || last !== pl)) hold_bad++;
                prev_stall = !ray_ready;
                pa = addr;
                pp = pixel;
                pl = last;
                if (ray_ready) k++;
            end
            cyc++;
            @(posedge clk);
            #1;
            ray_ready = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        ray_ready = 1'b1;
        chk("beats_accepted", k, SH);
        chk("pixel_errs", pix_bad, 0);
        chk("addr_errs", addr_bad, 0);
        chk("last_errs", last_bad, 0);
        chk("hold_errs", hold_bad, 0);
        chk("valid_gaps", gap_bad, 0);
        chk("tready_during_draw", rdy_bad, 0);
        if (!v.stall) chk("unstalled_cycles", cyc, SH);
        @(negedge clk);
        chk("post_col_valid", {31'd0, valid}, 32'd0);
        chk("post_col_tready", {31'd0, tready}, 32'd1);
    endtask

    initial begin
        int vcount;
        vecs[0] = '{9'd5,   8'd100, 1'b0, 4'd1, 1'b0, 1'b0, 70,  169, 16'hFA08};
        vecs[1] = '{9'd5,   8'd100, 1'b1, 4'd1, 1'b0, 1'b0, 70,  169, 16'h7904};
        vecs[2] = '{9'd319, 8'd255, 1'b0, 4'd0, 1'b1, 1'b0, 0,   239, 16'hF81F};
        vecs[3] = '{9'd100, 8'd0,   1'b0, 4'd7, 1'b0, 1'b0, 120, 119, 16'hFFFF};
        vecs[4] = '{9'd0,   8'd239, 1'b1, 4'd6, 1'b1, 1'b1, 0,   238, 16'h23EF};
        vecs[5] = '{9'd7,   8'd240, 1'b0, 4'd9, 1'b0, 1'b1, 0,   239, 16'hFA08};
        vecs[6] = '{9'd320, 8'd100, 1'b0, 4'd1, 1'b1, 1'b0, 0,   0,   16'h0000};

        rst_n = 1'b0;
        tvalid = 1'b0;
        tdata = '0;
        tlast = 1'b0;
        ray_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_addr", {15'd0, addr}, 32'd0);
        chk("rst_pixel", {16'd0, pixel}, 32'd0);
        chk("rst_last_err", {30'd0, last, err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_tready", {31'd0, tready}, 32'd1);
        chk("post_rst_valid", {31'd0, valid}, 32'd0);

        for (int i = 0; i < 6; i++) run_column(vecs[i]);
        chk("no_err_after_valid_cols", {31'd0, err}, 32'd0);

        // Out-of-range hcount: consumed, no writes, sticky error
        send_desc(vecs[6]);
        vcount = 0;
        @(negedge clk);
        chk("oor_err", {31'd0, err}, 32'd1);
        chk("oor_tready", {31'd0, tready}, 32'd1);
        repeat (10) begin
            if (valid) vcount++;
            @(negedge clk);
        end
        chk("oor_no_writes", vcount, 0);
        chk("oor_err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-column abandons the column immediately
        send_desc(vecs[0]);
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_addr", {15'd0, addr}, 32'd0);
        chk("midrst_pixel", {16'd0, pixel}, 32'd0);
        chk("midrst_last", {31'd0, last}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_tready", {31'd0, tready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_column(vecs[2]);
        chk("resume_err", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/column_rasterizer.md
Name: column_rasterizer

Overview:
- Consumer end of the DDA-out stream: pops one column descriptor per transfer from the DDA-out FIFO receiver interface.
- Expands each descriptor into SCREEN_HEIGHT per-pixel frame-buffer writes: ceiling, then wall, then floor, top to bottom.
- Sits between the DDA-out FIFO and the frame buffer write port (ray_address/ray_pixel/ray_last_pixel).

Parameters:
- SCREEN_WIDTH, 320, columns per frame; valid hcount range is 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 240, rows per column.
- ADDR_WIDTH, 17, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= SCREEN_WIDTH*SCREEN_HEIGHT.
- CEIL_COLOR, 16'h2104, RGB565 ceiling colour.
- FLOOR_COLOR, 16'h4208, RGB565 floor colour.

Ports:
- pixel_clk_in  in  1  sole clock.
- rst_in  in  1  asynchronous, active-low reset.
- dda_fifo_tvalid_in  in  1  descriptor valid.
- dda_fifo_tdata_in  in  38  [37:29] hcount, [28:21] line_height, [20] wall_type (1 = y-side), [19:16] map_data, [15:0] wallX (unused, reserved).
- dda_fifo_tlast_in  in  1  descriptor is the last column of the frame.
- transformer_tready_out  out  1  ready to accept a descriptor.
- ray_ready_in  in  1  frame buffer accepts a write this cycle.
- ray_valid_out  out  1  write valid.
- ray_address_out  out  ADDR_WIDTH  y*SCREEN_WIDTH + hcount.
- ray_pixel_out  out  16  RGB565 pixel value.
- ray_last_pixel_out  out  1  final pixel of the tlast column.
- err_out  out  1  sticky flag: an out-of-range hcount was received.

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE; transformer_tready_out=0, ray_valid_out=0, ray_address_out=0, ray_pixel_out=0, ray_last_pixel_out=0, err_out=0. A column in progress is abandoned; no further writes for it.
- States:
  - IDLE: tready=1. A transfer occurs on tvalid&tready. On transfer, latch fields, compute draw_start/draw_end, and go to DRAW.
  - DRAW: tready=0. Emit rows y=0..SCREEN_HEIGHT-1.
  - After the beat with y=SCREEN_HEIGHT-1 is accepted, return to IDLE. tready rises the next cycle, so there is one bubble cycle per column.
- Latency: descriptor accepted at edge N; first write (y=0) valid after edge N+1. Unstalled column = SCREEN_HEIGHT+1 cycles.
- Output handshake: a beat is consumed when ray_valid_out & ray_ready_in. While ray_ready_in=0, address, pixel and last are held stable. Address increments by SCREEN_WIDTH per consumed beat, starting at hcount; no multiplier.
- Draw window, lh = line_height:
  - lh >= SCREEN_HEIGHT: draw_start=0, draw_end=SCREEN_HEIGHT-1.
  - Otherwise: draw_start = (SCREEN_HEIGHT - lh) >> 1, draw_end = draw_start + lh - 1.
  - lh=0: no wall rows.
- Pixel select: y<draw_start → CEIL_COLOR; draw_start<=y<=draw_end → wall colour; y>draw_end → FLOOR_COLOR.
- Wall colour:
  - map_data=0: 16'hF81F (marker).
  - Otherwise: R5 = map_data[0]?31:8, G6 = map_data[1]?63:16, B5 = map_data[2]?31:8; map_data[3] is ignored.
  - wall_type=1: each channel is logically shifted right by 1.
- ray_last_pixel_out = 1 only on the y=SCREEN_HEIGHT-1 beat of a column latched with tlast=1. It is qualified by ray_valid_out.
- hcount >= SCREEN_WIDTH: descriptor is consumed, no writes are made, FSM stays in IDLE, err_out sets and stays set until reset. A tlast on such a descriptor is dropped.
- tvalid during DRAW is ignored (tready=0); the FIFO holds the data.

Test Plan:
- Reset held 5 cycles, then released with tvalid=0 → all outputs 0, tready=1, no writes.
- Descriptor hcount=5, lh=100, wall_type=0, map_data=1, tlast=0, ray_ready_in=1 → 240 writes on consecutive cycles, first one cycle after acceptance:
  - addresses 5, 325, …, 76485;
  - y 0..69 = 16'h2104, y 70..169 = 16'hFA08, y 170..239 = 16'h4208;
  - last never asserted; tready returns after 241 cycles.
- Same descriptor with wall_type=1 → wall rows = 16'h7904.
- hcount=319, lh=255, map_data=0, tlast=1 → all 240 rows = 16'hF81F; final address 76799 with ray_last_pixel_out=1 on that beat only.
- Random ray_ready_in deasserts during a column → outputs held while stalled; exactly 240 accepted beats with a gap-free address sequence.
- hcount=320 → consumed in one cycle, zero writes, err_out=1 sticky. Then rst_in=0 mid-column on the next descriptor → outputs clear immediately; resumes cleanly after release.
